// File: rtl/dpram_ext_pkg.sv
// dpram_ext_pkg: shared types and constants for the dpram_ext dual-port RAM.
//   state_e     - controller state (array clear / normal operation)
//   DEF_DATA_W  - default word width
//   DEF_ADDR_W  - default address width
//   COLL_CNT_W  - width of the saturating collision counter
//   sat_inc()   - saturating increment for the collision counter
package dpram_ext_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned COLL_CNT_W = 16;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [COLL_CNT_W-1:0] sat_inc(input logic [COLL_CNT_W-1:0] v);
        return (&v) ? v : v + COLL_CNT_W'(1);
    endfunction

endpackage

// File: rtl/dpram_ext_rd_port.sv
// dpram_ext_rd_port: per-port read-data register, read-valid pulse and parity check.
// Optional feature macro: DPRAM_EXT_PARITY_EN (parity bit in the MSB of i_rd_word).
// Ports:
//   clk, rst_n   - clock, async active-low reset
//   i_rd_en      - a read is accepted at this edge
//   i_rd_word    - stored word at the read address (pre-write contents)
//   o_dout       - registered read data, holds when no read completes
//   o_rvalid     - one-cycle pulse, o_dout valid
//   o_perr       - parity mismatch pulse aligned with o_rvalid (0 without parity)
module dpram_ext_rd_port
    import dpram_ext_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned WORD_W = DEF_DATA_W
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_rd_en,
    input  logic [WORD_W-1:0] i_rd_word,
    output logic [DATA_W-1:0] o_dout,
    output logic              o_rvalid,
    output logic              o_perr
);

    logic [DATA_W-1:0] r_dout;
    logic              r_rvalid;

    // Read data capture; dout only changes when a read completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout   <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= i_rd_en;
            if (i_rd_en) begin
                r_dout <= i_rd_word[DATA_W-1:0];
            end
        end
    end

    assign o_dout   = r_dout;
    assign o_rvalid = r_rvalid;

`ifdef DPRAM_EXT_PARITY_EN
    logic r_perr;

    // Even parity over data plus stored parity bit must reduce to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perr <= 1'b0;
        end else begin
            r_perr <= i_rd_en & (^i_rd_word);
        end
    end

    assign o_perr = r_perr;
`else
    assign o_perr = 1'b0;
`endif

endmodule

// File: rtl/dpram_ext.sv
// dpram_ext: true dual-port RAM with post-reset zero fill, read-during-write
// returning old data, same-address write collision detection and optional parity.
// Optional feature macro: DPRAM_EXT_PARITY_EN (one even-parity bit per word).
// Ports:
//   clk, rst_n                - clock, async active-low reset
//   en_a/en_b, wr_a/wr_b      - per-port enable and write(1)/read(0)
//   addr_a/addr_b, din_a/din_b- word address and write data
//   dout_a/dout_b             - registered read data (latency 1)
//   rvalid_a/rvalid_b         - read data valid pulse
//   init_busy                 - array clear in progress, accesses ignored
//   collision                 - pulse after a same-address dual write
//   coll_cnt                  - saturating collision count since reset
//   perr_a/perr_b             - parity error pulse aligned with rvalid
module dpram_ext
    import dpram_ext_pkg::*;
#(
    parameter int unsigned DATA_W         = DEF_DATA_W,
    parameter int unsigned ADDR_W         = DEF_ADDR_W,
    parameter int unsigned CLEAR_ON_RESET = 1
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_a,
    input  logic                  en_b,
    input  logic                  wr_a,
    input  logic                  wr_b,
    input  logic [ADDR_W-1:0]     addr_a,
    input  logic [ADDR_W-1:0]     addr_b,
    input  logic [DATA_W-1:0]     din_a,
    input  logic [DATA_W-1:0]     din_b,
    output logic [DATA_W-1:0]     dout_a,
    output logic [DATA_W-1:0]     dout_b,
    output logic                  rvalid_a,
    output logic                  rvalid_b,
    output logic                  init_busy,
    output logic                  collision,
    output logic [COLL_CNT_W-1:0] coll_cnt,
    output logic                  perr_a,
    output logic                  perr_b
);

    localparam int unsigned DEPTH = 2**ADDR_W;
`ifdef DPRAM_EXT_PARITY_EN
    localparam int unsigned WORD_W = DATA_W + 1;
`else
    localparam int unsigned WORD_W = DATA_W;
`endif

    state_e                r_state;
    state_e                w_state_nxt;
    logic [ADDR_W-1:0]     r_clr_addr;
    logic [ADDR_W-1:0]     w_clr_addr_nxt;
    logic                  r_init_busy;
    logic                  w_busy_nxt;
    logic                  w_clr_we;

    logic                  r_collision;
    logic [COLL_CNT_W-1:0] r_coll_cnt;

    logic                  w_acc_ok;
    logic                  w_rd_a;
    logic                  w_rd_b;
    logic                  w_we_a;
    logic                  w_we_b;
    logic                  w_coll;
    logic [WORD_W-1:0]     w_wdata_a;
    logic [WORD_W-1:0]     w_wdata_b;
    logic [WORD_W-1:0]     w_rd_word_a;
    logic [WORD_W-1:0]     w_rd_word_b;

    logic [WORD_W-1:0]     r_mem [DEPTH];

    // Controller state register; without clearing the RAM is usable straight after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_READY;
            r_clr_addr  <= '0;
            r_init_busy <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_clr_addr  <= w_clr_addr_nxt;
            r_init_busy <= w_busy_nxt;
        end
    end

    // Next state: sweep every address once, then hand over to normal operation.
    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        w_clr_we       = 1'b0;
        w_busy_nxt     = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_clr_we       = 1'b1;
                w_busy_nxt     = 1'b1;
                w_clr_addr_nxt = r_clr_addr + ADDR_W'(1);
                if (r_clr_addr == '1) begin
                    w_state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                w_state_nxt = ST_READY;
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    // Accesses are dropped until the clear has finished and init_busy has dropped.
    assign w_acc_ok = (r_state == ST_READY) && !r_init_busy;
    assign w_rd_a   = w_acc_ok & en_a & ~wr_a;
    assign w_rd_b   = w_acc_ok & en_b & ~wr_b;
    assign w_we_a   = w_acc_ok & en_a & wr_a;
    assign w_we_b   = w_acc_ok & en_b & wr_b;
    assign w_coll   = w_we_a & w_we_b & (addr_a == addr_b);

`ifdef DPRAM_EXT_PARITY_EN
    assign w_wdata_a = {^din_a, din_a};
    assign w_wdata_b = {^din_b, din_b};
`else
    assign w_wdata_a = din_a;
    assign w_wdata_b = din_b;
`endif

    // Storage array, never reset; port A is written last so it wins a collision.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_clr_addr] <= '0;
        end
        if (w_we_b && !w_coll) begin
            r_mem[addr_b] <= w_wdata_b;
        end
        if (w_we_a) begin
            r_mem[addr_a] <= w_wdata_a;
        end
    end

    // Combinational lookup is sampled at the same edge as any write, giving old data.
    assign w_rd_word_a = r_mem[addr_a];
    assign w_rd_word_b = r_mem[addr_b];

    // Collision pulse and saturating count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_collision <= 1'b0;
            r_coll_cnt  <= '0;
        end else begin
            r_collision <= w_coll;
            if (w_coll) begin
                r_coll_cnt <= sat_inc(r_coll_cnt);
            end
        end
    end

    assign init_busy = r_init_busy;
    assign collision = r_collision;
    assign coll_cnt  = r_coll_cnt;

    dpram_ext_rd_port #(
        .DATA_W (DATA_W),
        .WORD_W (WORD_W)
    ) u_rd_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_rd_en   (w_rd_a),
        .i_rd_word (w_rd_word_a),
        .o_dout    (dout_a),
        .o_rvalid  (rvalid_a),
        .o_perr    (perr_a)
    );

    dpram_ext_rd_port #(
        .DATA_W (DATA_W),
        .WORD_W (WORD_W)
    ) u_rd_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_rd_en   (w_rd_b),
        .i_rd_word (w_rd_word_b),
        .o_dout    (dout_b),
        .o_rvalid  (rvalid_b),
        .o_perr    (perr_b)
    );

endmodule

// File: tb/tb_dpram_ext.sv
// tb_dpram_ext: directed bench for dpram_ext with a cycle-level behavioural model
// and an every-cycle output compare, plus hand-computed literal expectations.
module tb_dpram_ext;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 8;
    localparam int unsigned DEPTH = 256;
`ifdef DPRAM_EXT_PARITY_EN
    localparam bit EXP_PERR = 1'b1;
`else
    localparam bit EXP_PERR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en_a = 1'b0, en_b = 1'b0, wr_a = 1'b0, wr_b = 1'b0;
    logic [AW-1:0] addr_a = '0, addr_b = '0;
    logic [DW-1:0] din_a = '0, din_b = '0;
    logic [DW-1:0] dout_a, dout_b;
    logic          rvalid_a, rvalid_b, init_busy, collision, perr_a, perr_b;
    logic [15:0]   coll_cnt;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    dpram_ext #(
        .DATA_W         (DW),
        .ADDR_W         (AW),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_a      (en_a),
        .en_b      (en_b),
        .wr_a      (wr_a),
        .wr_b      (wr_b),
        .addr_a    (addr_a),
        .addr_b    (addr_b),
        .din_a     (din_a),
        .din_b     (din_b),
        .dout_a    (dout_a),
        .dout_b    (dout_b),
        .rvalid_a  (rvalid_a),
        .rvalid_b  (rvalid_b),
        .init_busy (init_busy),
        .collision (collision),
        .coll_cnt  (coll_cnt),
        .perr_a    (perr_a),
        .perr_b    (perr_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    // After reset release: edges 1..DEPTH show busy, accesses honoured from edge DEPTH+2.
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_flip40 = 1'b0;
    int            m_edges = 0;
    logic [DW-1:0] e_dout_a = '0, e_dout_b = '0;
    logic          e_rv_a = 1'b0, e_rv_b = 1'b0, e_busy = 1'b0, e_coll = 1'b0;
    logic          e_perr_a = 1'b0, e_perr_b = 1'b0;
    logic [15:0]   e_cnt = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_edges  <= 0;
            e_dout_a <= '0;
            e_dout_b <= '0;
            e_rv_a   <= 1'b0;
            e_rv_b   <= 1'b0;
            e_busy   <= 1'b0;
            e_coll   <= 1'b0;
            e_cnt    <= '0;
            e_perr_a <= 1'b0;
            e_perr_b <= 1'b0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
        end else begin
            m_edges  <= (m_edges < 1000) ? m_edges + 1 : m_edges;
            e_busy   <= (m_edges < DEPTH);
            e_rv_a   <= 1'b0;
            e_rv_b   <= 1'b0;
            e_coll   <= 1'b0;
            e_perr_a <= 1'b0;
            e_perr_b <= 1'b0;
            if (m_edges > DEPTH) begin
                if (en_a && !wr_a) begin
                    e_rv_a   <= 1'b1;
                    e_dout_a <= m_mem[addr_a];
                    e_perr_a <= m_flip40 && (addr_a == 8'h40);
                end
                if (en_b && !wr_b) begin
                    e_rv_b   <= 1'b1;
                    e_dout_b <= m_mem[addr_b];
                    e_perr_b <= m_flip40 && (addr_b == 8'h40);
                end
                if (en_b && wr_b && !(en_a && wr_a && addr_a == addr_b)) m_mem[addr_b] <= din_b;
                if (en_a && wr_a) m_mem[addr_a] <= din_a;
                if (en_a && wr_a && en_b && wr_b && addr_a == addr_b) begin
                    e_coll <= 1'b1;
                    e_cnt  <= (e_cnt == 16'hFFFF) ? e_cnt : e_cnt + 16'd1;
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        check("dout_a",    32'(dout_a),    32'(e_dout_a));
        check("dout_b",    32'(dout_b),    32'(e_dout_b));
        check("rvalid_a",  32'(rvalid_a),  32'(e_rv_a));
        check("rvalid_b",  32'(rvalid_b),  32'(e_rv_b));
        check("init_busy", 32'(init_busy), 32'(e_busy));
        check("collision", 32'(collision), 32'(e_coll));
        check("coll_cnt",  32'(coll_cnt),  32'(e_cnt));
        check("perr_a",    32'(perr_a),    32'(e_perr_a));
        check("perr_b",    32'(perr_b),    32'(e_perr_b));
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic ea, input logic wa, input logic [7:0] aa, input logic [7:0] da,
                         input logic eb, input logic wb, input logic [7:0] ab, input logic [7:0] db);
        @(negedge clk);
        #2;
        en_a = ea; wr_a = wa; addr_a = aa; din_a = da;
        en_b = eb; wr_b = wb; addr_b = ab; din_b = db;
    endtask

    task automatic idle();
        drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    endtask

    task automatic wait_init(output int cnt);
        bit seen;
        seen = 1'b0;
        cnt  = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (init_busy) begin
                cnt++;
                seen = 1'b1;
            end else if (seen) begin
                break;
            end
        end
    endtask

    initial begin
        int cnt;
        repeat (3) @(negedge clk);
        check("rst_dout_a", 32'(dout_a), 32'h0);
        check("rst_busy", 32'(init_busy), 32'h0);
        check("rst_cnt", 32'(coll_cnt), 32'h0);
        #2 rst_n = 1'b1;

        wait_init(cnt);
        check("init_len", 32'(cnt), 32'd256);

        // Cleared word at top of the array, latency one.
        drive(1, 0, 8'hFF, 8'h00, 0, 0, 8'h00, 8'h00);
        idle();
        check("rd_ff_valid", 32'(rvalid_a), 32'h1);
        check("rd_ff_data", 32'(dout_a), 32'h00);
        idle();
        check("rd_ff_pulse", 32'(rvalid_a), 32'h0);

        // Cross-port write then read.
        drive(1, 1, 8'h10, 8'h5A, 0, 0, 8'h00, 8'h00);
        drive(0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00);
        idle();
        check("xport_data", 32'(dout_b), 32'h5A);
        check("xport_valid", 32'(rvalid_b), 32'h1);

        // Same-address dual write.
        drive(1, 1, 8'h20, 8'h11, 1, 1, 8'h20, 8'h22);
        idle();
        check("coll_pulse", 32'(collision), 32'h1);
        check("coll_cnt1", 32'(coll_cnt), 32'h1);
        idle();
        check("coll_end", 32'(collision), 32'h0);
        drive(0, 0, 8'h00, 8'h00, 1, 0, 8'h20, 8'h00);
        idle();
        check("coll_winner", 32'(dout_b), 32'h11);

        // Read-during-write returns old data, both port pairings.
        drive(1, 1, 8'h30, 8'h01, 0, 0, 8'h00, 8'h00);
        drive(1, 1, 8'h30, 8'h02, 1, 0, 8'h30, 8'h00);
        idle();
        check("rdw_old_b", 32'(dout_b), 32'h01);
        drive(0, 0, 8'h00, 8'h00, 1, 0, 8'h30, 8'h00);
        idle();
        check("rdw_new_b", 32'(dout_b), 32'h02);
        drive(1, 0, 8'h31, 8'h00, 1, 1, 8'h31, 8'h77);
        idle();
        check("rdw_old_a", 32'(dout_a), 32'h00);
        drive(1, 0, 8'h31, 8'h00, 0, 0, 8'h00, 8'h00);
        idle();
        check("rdw_new_a", 32'(dout_a), 32'h77);

        // Dual write, different addresses.
        drive(1, 1, 8'h50, 8'hA5, 1, 1, 8'h51, 8'h3C);
        drive(1, 0, 8'h51, 8'h00, 1, 0, 8'h50, 8'h00);
        idle();
        check("dual_a", 32'(dout_a), 32'h3C);
        check("dual_b", 32'(dout_b), 32'hA5);
        check("dual_nocoll", 32'(coll_cnt), 32'h1);

        // Parity: corrupt the stored parity bit at 0x40 when the feature exists.
        drive(1, 1, 8'h40, 8'h07, 0, 0, 8'h00, 8'h00);
        idle();
`ifdef DPRAM_EXT_PARITY_EN
        dut.r_mem[8'h40][DW] = ~dut.r_mem[8'h40][DW];
        m_flip40 = 1'b1;
`endif
        drive(1, 0, 8'h40, 8'h00, 0, 0, 8'h00, 8'h00);
        idle();
        check("par_valid", 32'(rvalid_a), 32'h1);
        check("par_data", 32'(dout_a), 32'h07);
        check("par_perr", 32'(perr_a), 32'(EXP_PERR));
        m_flip40 = 1'b0;
        drive(1, 1, 8'h40, 8'h07, 0, 0, 8'h00, 8'h00);

        // Reset in the middle of a read completing.
        drive(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
        @(posedge clk);
        #1;
        check("pre_rst_data", 32'(dout_a), 32'h5A);
        check("pre_rst_cnt", 32'(coll_cnt), 32'h1);
        rst_n = 1'b0;
        #1;
        check("arst_dout_a", 32'(dout_a), 32'h0);
        check("arst_rvalid_a", 32'(rvalid_a), 32'h0);
        check("arst_cnt", 32'(coll_cnt), 32'h0);
        en_a = 1'b0;
        repeat (2) @(negedge clk);

        // Reset again at clear address ~100, with accesses attempted during the clear.
        #2 rst_n = 1'b1;
        en_a = 1'b1; wr_a = 1'b1; addr_a = 8'h33; din_a = 8'hEE;
        en_b = 1'b1; wr_b = 1'b0; addr_b = 8'h10;
        repeat (101) @(negedge clk);
        check("mid_init_busy", 32'(init_busy), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(init_busy), 32'h0);
        check("mid_rst_rv_b", 32'(rvalid_b), 32'h0);
        en_a = 1'b0; wr_a = 1'b0; en_b = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        wait_init(cnt);
        check("reinit_len", 32'(cnt), 32'd256);

        // Contents written before the reset must now read as zero.
        drive(1, 1, 8'h60, 8'h99, 0, 0, 8'h00, 8'h00);
        drive(1, 0, 8'h60, 8'h00, 1, 0, 8'h10, 8'h00);
        drive(1, 0, 8'h33, 8'h00, 0, 0, 8'h00, 8'h00);
        check("post_w_data", 32'(dout_a), 32'h99);
        check("post_clr_10", 32'(dout_b), 32'h00);
        idle();
        check("post_clr_33", 32'(dout_a), 32'h00);
        check("post_cnt", 32'(coll_cnt), 32'h0);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
